// File: rtl/adder_pkg.sv
// adder_pkg
//   Shared definitions for the bit-serial adder.
//   - DEFAULT_WIDTH : default operand / sum width in bits
//   - state_t and ST_IDLE / ST_RUN / ST_DONE : controller state encoding
package adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/fa_cell.sv
// fa_cell
//   One-bit full adder used as the arithmetic core of the serial adder.
//   Ports:
//     a, b  : operand bits
//     cin   : carry in
//     s     : sum bit
//     cout  : carry out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial unsigned adder. A start request captures both operands and the
//   carry-in, then one bit is summed per clock through a single full-adder
//   cell, LSB first. After WIDTH run cycles the result is published on s/cout
//   and done pulses for one cycle.
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     start  : begin an addition (accepted in IDLE or DONE)
//     a, b   : unsigned operands, sampled when start is accepted
//     cin    : carry in, sampled when start is accepted
//     busy   : high while the addition is running
//     done   : one-cycle pulse when s/cout carry a new result
//     s      : registered sum
//     cout   : registered carry out of the top bit
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  // Counter value seen on the final run edge; the counter ends at WIDTH,
  // which still fits in CW bits, so it never wraps.
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] psum_shift;

  fa_cell u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  // Written on a WIDTH+1 vector so it also works for WIDTH=1.
  assign psum_shift = WIDTH'({fa_s, psum_q} >> 1);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;

    case (state_q)
      ST_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        psum_d  = psum_shift;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          s_d     = psum_shift;
          cout_d  = fa_cout;
          state_d = ST_DONE;
        end
      end
      // IDLE and DONE both accept a new request; any unused encoding
      // falls back to IDLE.
      default: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          psum_d  = '0;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign s    = s_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Directed and randomized checks of serial_adder at WIDTH = 4, 8 and 1.
//   Three instances share clk and rst_n; instance ids 0/1/2 select W4/W8/W1.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, s4;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, s8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, s1;

  serial_adder #(.WIDTH(4)) u_add4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .s(s4), .cout(cout4)
  );

  serial_adder #(.WIDTH(8)) u_add8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) u_add1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .s(s1), .cout(cout1)
  );

  int checks = 0;
  int failures = 0;

  // Last published {cout,s} per instance, as predicted by the reference model
  longint unsigned prevRes [3];

  function automatic int widthOf(input int id);
    case (id)
      0:       return 4;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  // Observed result packed as cout*2^W + s
  function automatic longint unsigned resultOf(input int id);
    case (id)
      0:       return (longint'(cout4) << 4) | longint'(s4);
      1:       return (longint'(cout8) << 8) | longint'(s8);
      default: return (longint'(cout1) << 1) | longint'(s1);
    endcase
  endfunction

  function automatic longint unsigned busyOf(input int id);
    case (id)
      0:       return longint'(busy4);
      1:       return longint'(busy8);
      default: return longint'(busy1);
    endcase
  endfunction

  function automatic longint unsigned doneOf(input int id);
    case (id)
      0:       return longint'(done4);
      1:       return longint'(done8);
      default: return longint'(done1);
    endcase
  endfunction

  // Reference model: plain arithmetic on the accepted operands
  function automatic longint unsigned modelSum(input int w, input longint unsigned av,
                                               input longint unsigned bv, input logic c);
    longint unsigned opMask;
    longint unsigned resMask;
    opMask  = (64'd1 << w) - 1;
    resMask = (64'd1 << (w + 1)) - 1;
    return ((av & opMask) + (bv & opMask) + longint'(c)) & resMask;
  endfunction

  task automatic setInputs(input int id, input logic st, input longint unsigned av,
                           input longint unsigned bv, input logic c);
    case (id)
      0: begin start4 = st; a4 = av[3:0]; b4 = bv[3:0]; cin4 = c; end
      1: begin start8 = st; a8 = av[7:0]; b8 = bv[7:0]; cin8 = c; end
      default: begin start1 = st; a1 = av[0:0]; b1 = bv[0:0]; cin1 = c; end
    endcase
  endtask

  task automatic checkOutput(input string tag, input longint unsigned observed,
                             input longint unsigned expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one addition on instance id and follow it to its done pulse.
  // glitchAt > 0 raises start with all-ones operands during that RUN cycle.
  // releaseReset deasserts rst_n on the same negedge start is raised.
  task automatic applyStimulus(input int id, input longint unsigned av,
                               input longint unsigned bv, input logic c,
                               input int glitchAt, input bit releaseReset);
    int w;
    longint unsigned expected;
    w = widthOf(id);
    expected = modelSum(w, av, bv, c);
    @(negedge clk);
    if (releaseReset) rst_n = 1'b1;
    setInputs(id, 1'b1, av, bv, c);
    @(posedge clk);
    #1;
    setInputs(id, 1'b0, $urandom, $urandom, 1'($urandom));
    checkOutput("busy_after_accept", busyOf(id), 1);
    for (int k = 1; k <= w; k++) begin
      if (k == glitchAt) setInputs(id, 1'b1, 64'hFFFF, 64'hFFFF, 1'b1);
      @(posedge clk);
      #1;
      setInputs(id, 1'b0, $urandom, $urandom, 1'($urandom));
      if (k < w) begin
        checkOutput("no_early_done", doneOf(id), 0);
        checkOutput("busy_in_run", busyOf(id), 1);
        checkOutput("result_hold_in_run", resultOf(id), prevRes[id]);
      end
    end
    checkOutput("done_pulse", doneOf(id), 1);
    checkOutput("busy_at_done", busyOf(id), 0);
    checkOutput("result", resultOf(id), expected);
    prevRes[id] = expected;
  endtask

  // One idle cycle: done must have fallen, result must hold
  task automatic expectIdle(input int id);
    @(posedge clk);
    #1;
    checkOutput("done_falls", doneOf(id), 0);
    checkOutput("busy_idle", busyOf(id), 0);
    checkOutput("result_hold_idle", resultOf(id), prevRes[id]);
  endtask

  initial begin
    longint unsigned ra;
    longint unsigned rb;
    logic rc;

    for (int i = 0; i < 3; i++) begin
      prevRes[i] = 0;
      setInputs(i, 1'b0, 0, 0, 1'b0);
    end

    // Reset state, observed before any clock edge
    #2;
    for (int i = 0; i < 3; i++) begin
      checkOutput("reset_busy", busyOf(i), 0);
      checkOutput("reset_done", doneOf(i), 0);
      checkOutput("reset_result", resultOf(i), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // W4: 9 + 3 -> 12, done in the cycle after the 4th RUN edge
    applyStimulus(0, 9, 3, 1'b0, 0, 1'b0);
    expectIdle(0);

    // W4: overflow, then back-to-back from DONE
    applyStimulus(0, 15, 1, 1'b0, 0, 1'b0);
    applyStimulus(0, 5, 10, 1'b1, 0, 1'b0);
    expectIdle(0);

    // W4: start pulsed mid-run must not disturb the operation
    applyStimulus(0, 3, 4, 1'b0, 2, 1'b0);
    expectIdle(0);
    expectIdle(0);

    // W1: full-adder truth table
    for (int i = 0; i < 8; i++) begin
      applyStimulus(2, longint'(i & 1), longint'((i >> 1) & 1), 1'(i >> 2), 0, 1'b0);
      expectIdle(2);
    end

    // Randomized operations on W4 and W8, with random back-to-back and glitches
    for (int n = 0; n < 12; n++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom);
      applyStimulus(n % 2, ra, rb, rc, int'($urandom_range(0, 4)), 1'b0);
      if ($urandom_range(0, 1) == 1) expectIdle(n % 2);
    end
    expectIdle(0);
    expectIdle(1);

    // W8: give it a nonzero result, then abort a run with reset
    applyStimulus(1, 200, 100, 1'b1, 0, 1'b0);
    expectIdle(1);
    @(negedge clk);
    setInputs(1, 1'b1, 200, 100, 1'b0);
    @(posedge clk);
    #1;
    setInputs(1, 1'b0, 0, 0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) prevRes[i] = 0;
    checkOutput("abort_busy", busyOf(1), 0);
    checkOutput("abort_done", doneOf(1), 0);
    checkOutput("abort_result", resultOf(1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) expectIdle(1);

    // First start after reset release is accepted at the first edge
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(1, 77, 180, 1'b1, 0, 1'b1);
    expectIdle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits; legal range 1..64.
REQ-002 clk  input  1  rising-edge system clock, the only clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 a  input  WIDTH  operand A, unsigned; sampled only when start is accepted.
REQ-006 b  input  WIDTH  operand B, unsigned; sampled only when start is accepted.
REQ-007 cin  input  1  carry-in; sampled only when start is accepted.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  single-cycle pulse: s/cout now hold the new result.
REQ-010 s  output  WIDTH  registered sum, LSB = bit 0.
REQ-011 cout  output  1  registered carry-out of bit WIDTH-1.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-013 In IDLE or DONE, start=1 at a rising edge SHALL be accepted:
- capture a and b into internal shift registers
- load the carry flop with cin
- clear the bit counter
- enter RUN
REQ-014 In RUN, each rising edge SHALL add the LSBs of both shift registers and the carry flop with one full-adder cell, then:
- shift the sum bit into the MSB of a partial-sum register
- update the carry flop
- shift both operand registers right by one
- increment the bit counter
REQ-015 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap during an operation.
REQ-016 On the WIDTH-th RUN edge:
- s SHALL take the completed partial sum
- cout SHALL take the final carry
- the FSM SHALL enter DONE
REQ-017 Latency: if start is accepted at edge E0, done SHALL be high for exactly the cycle following edge E(WIDTH).
REQ-018 DONE SHALL return to IDLE on the next edge unless start=1, in which case REQ-013 applies (back-to-back, no idle cycle).
REQ-019 busy SHALL equal 1 exactly while the state is RUN.
REQ-020 start while in RUN SHALL be ignored; operands and carry in flight are unaffected.
REQ-021 s and cout SHALL hold their previous values throughout RUN and change only at the REQ-016 edge.
REQ-022 Result: {cout,s} SHALL equal a + b + cin modulo 2^(WIDTH+1) for the values captured at acceptance.
REQ-023 For WIDTH=1, the block SHALL complete in one RUN cycle with full-adder truth-table results.

Reset
REQ-024 rst_n=0 SHALL immediately, independent of clk, force:
- state to IDLE
- busy=0, done=0, s=0, cout=0
- shift registers, carry flop and counter to 0
REQ-025 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-026 The first start after rst_n deasserts SHALL be accepted at the first rising edge with rst_n=1.

Structure
REQ-027 Shared package adder_pkg SHALL hold the state enumeration (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-028 The per-bit sum/carry logic SHALL be one instantiated sub-module, fa_cell (inputs a, b, cin; outputs s, cout).
REQ-029 All other logic (FSM, counter, shift registers, output registers) SHALL live in serial_adder.

Verification
REQ-030 WIDTH=4, a=9, b=3, cin=0:
- done high 5 cycles after start sampled
- s=12, cout=0
REQ-031 WIDTH=4, a=15, b=1, cin=0 -> s=0, cout=1; then a=5, b=10, cin=1 back-to-back from DONE -> s=0, cout=1 with no idle cycle between operations.
REQ-032 WIDTH=4, a=3, b=4 started; start pulsed with a=15, b=15 on the 2nd RUN cycle -> result s=7, cout=0; exactly one done pulse.
REQ-033 WIDTH=8, a=200, b=100 started; rst_n pulled low on the 3rd RUN cycle -> all outputs 0 immediately; no done until a new start.
REQ-034 WIDTH=1, all 8 {a,b,cin} combinations -> {cout,s} matches the full-adder truth table; done 2 cycles after each start sampled.
REQ-035 A self-checking bench SHALL compare every done-cycle result against a+b+cin and report any mismatch.
